// File: rtl/shift_register_universal.sv
// shift_register_universal: N-bit universal shifter with rotate, arithmetic shift,
// parallel load and an autonomous right-shift burst mode with done pulse.
module shift_register_universal #(
    parameter int N  = 8,
    parameter int LW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic [2:0]    op_i,
    input  logic [N-1:0]  d_i,
    input  logic [LW-1:0] len_i,
    input  logic          sin_l_i,
    input  logic          sin_r_i,
    output logic [N-1:0]  q_o,
    output logic          sout_r_o,
    output logic          sout_l_o,
    output logic          busy_o,
    output logic          done_o
);
    typedef enum logic {IDLE, SHIFT} state_t;
    localparam logic [LW-1:0] LEN_MAX = LW'(N);
    state_t        state_q, state_d;
    logic [N-1:0]  q_q, q_d;
    logic [LW-1:0] cnt_q, cnt_d, len_c;
    logic          done_q, done_d;
    assign len_c = (len_i > LEN_MAX) ? LEN_MAX : len_i;
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (state_q == SHIFT) begin
            q_d   = {sin_l_i, q_q[N-1:1]};
            cnt_d = cnt_q - LW'(1);
            if (cnt_q == LW'(1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end else if (en_i) begin
            case (op_i)
                3'b001:  q_d = {sin_l_i, q_q[N-1:1]};
                3'b010:  q_d = {q_q[N-2:0], sin_r_i};
                3'b011:  q_d = {q_q[0], q_q[N-1:1]};
                3'b100:  q_d = {q_q[N-2:0], q_q[N-1]};
                3'b101:  q_d = {q_q[N-1], q_q[N-1:1]};
                3'b110:  q_d = d_i;
                3'b111: begin
                    // zero-length burst completes immediately without entering SHIFT
                    cnt_d   = len_c;
                    done_d  = (len_c == '0);
                    state_d = (len_c == '0) ? IDLE : SHIFT;
                end
                default: q_d = q_q;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end
    assign q_o      = q_q;
    assign sout_r_o = q_q[0];
    assign sout_l_o = q_q[N-1];
    assign busy_o   = (state_q == SHIFT);
    assign done_o   = done_q;
endmodule

// File: tb/tb_shift_register_universal.sv
// tb_shift_register_universal: vector table, directed burst sequences and a
// randomized run against an arithmetic reference model.
module tb_shift_register_universal;
    localparam int N  = 8;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [2:0]    op;
    logic [N-1:0]  d;
    logic [LW-1:0] len;
    logic          sin_l, sin_r;
    logic [N-1:0]  q;
    logic          sout_r, sout_l, busy, done;

    int n_cmp = 0;
    int n_err = 0;

    shift_register_universal #(.N(N), .LW(LW)) dut (
        .clk(clk), .rst_n(rst_n), .en_i(en), .op_i(op), .d_i(d), .len_i(len),
        .sin_l_i(sin_l), .sin_r_i(sin_r), .q_o(q), .sout_r_o(sout_r),
        .sout_l_o(sout_l), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic       en;
        logic       sl;
        logic       sr;
        logic [7:0] exp;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic e, input logic [2:0] o, input logic [7:0] dv,
                       input logic [3:0] l, input logic sl, input logic sr);
        en = e; op = o; d = dv; len = l; sin_l = sl; sin_r = sr;
    endtask

    task automatic load(input logic [7:0] v);
        cmd(1, 3'b110, v, 0, 0, 0);
        tick();
        cmd(0, 3'b000, 0, 0, 0, 0);
    endtask

    // Reference model: register value as a plain integer, burst as a remaining-shift count
    int unsigned mq, rem;
    int          mdone;
    localparam int unsigned MASK = (1 << N) - 1;

    function automatic int unsigned model_op(input int unsigned v, input int o,
                                             input int sl, input int sr, input int unsigned dv);
        case (o)
            1: return (v >> 1) | (sl << (N - 1));
            2: return ((v << 1) | sr) & MASK;
            3: return (v >> 1) | ((v & 1) << (N - 1));
            4: return ((v << 1) | (v >> (N - 1))) & MASK;
            5: return (v >> 1) | (v & (1 << (N - 1)));
            6: return dv;
            default: return v;
        endcase
    endfunction

    task automatic model_edge();
        if (rem > 0) begin
            mq = (mq >> 1) | (int'(sin_l) << (N - 1));
            rem--;
            mdone = (rem == 0);
        end else begin
            mdone = 0;
            if (en) begin
                if (op == 3'b111) begin
                    rem   = (len > N) ? N : len;
                    mdone = (rem == 0);
                end else mq = model_op(mq, op, sin_l, sin_r, d);
            end
        end
    endtask

    vec_t vecs[7];
    int   cyc, dones;
    logic [7:0] sr_exp;

    initial begin
        vecs[0] = '{3'b001, 1, 1, 0, 8'hDA};
        vecs[1] = '{3'b010, 1, 1, 0, 8'h68};
        vecs[2] = '{3'b011, 1, 1, 0, 8'h5A};
        vecs[3] = '{3'b100, 1, 1, 0, 8'h69};
        vecs[4] = '{3'b101, 1, 1, 0, 8'hDA};
        vecs[5] = '{3'b000, 1, 1, 0, 8'hB4};
        vecs[6] = '{3'b001, 0, 1, 0, 8'hB4};

        rst_n = 1'b0;
        cmd(0, 0, 0, 0, 0, 0);
        #12;
        chk("reset_q", q, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        rst_n = 1'b1;
        tick();

        // asynchronous reset mid-operation
        load(8'hA5);
        chk("load_a5", q, 8'hA5);
        cmd(1, 3'b001, 0, 0, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_q", q, 0);
        chk("async_rst_sout", {sout_l, sout_r}, 0);
        chk("async_rst_busy", busy, 0);
        rst_n = 1'b1;
        cmd(0, 0, 0, 0, 0, 0);
        tick();

        for (int i = 0; i < 7; i++) begin
            load(8'hB4);
            cmd(vecs[i].en, vecs[i].op, 8'h00, 0, vecs[i].sl, vecs[i].sr);
            tick();
            chk($sformatf("vec%0d_q", i), q, vecs[i].exp);
            chk($sformatf("vec%0d_sout", i), {sout_l, sout_r}, {vecs[i].exp[7], vecs[i].exp[0]});
            cmd(0, 0, 0, 0, 0, 0);
        end

        // burst of 3 with an ignored load during busy, then a load accepted in the done cycle
        load(8'h81);
        cmd(1, 3'b111, 0, 3, 0, 0);
        tick();
        chk("burst_start_q", q, 8'h81);
        cmd(1, 3'b110, 8'hFF, 0, 0, 0);
        sr_exp = 8'b001;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("burst_busy%0d", i), busy, 1);
            chk($sformatf("burst_done%0d", i), done, 0);
            chk($sformatf("burst_sout_r%0d", i), sout_r, sr_exp[i]);
            tick();
        end
        chk("burst_end_q", q, 8'h10);
        chk("burst_end_busy", busy, 0);
        chk("burst_end_done", done, 1);
        cmd(1, 3'b110, 8'h3C, 0, 0, 0);
        tick();
        chk("b2b_load", q, 8'h3C);
        chk("b2b_done_low", done, 0);
        cmd(0, 0, 0, 0, 0, 0);

        // clamping: len=15 shifts exactly N bits
        load(8'h00);
        cmd(1, 3'b111, 0, 15, 1, 0);
        tick();
        cmd(0, 0, 0, 0, 1, 0);
        cyc = 0;
        while (busy && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("clamp_cycles", cyc, N);
        chk("clamp_q", q, 8'hFF);
        chk("clamp_done", done, 1);
        cmd(0, 0, 0, 0, 0, 0);
        tick();

        // zero-length burst
        load(8'h5A);
        cmd(1, 3'b111, 0, 0, 1, 0);
        tick();
        cmd(0, 0, 0, 0, 1, 0);
        chk("len0_busy", busy, 0);
        chk("len0_done", done, 1);
        chk("len0_q", q, 8'h5A);
        tick();
        chk("len0_done_once", done, 0);
        chk("len0_q_hold", q, 8'h5A);

        // abort: reset two cycles into a len=5 burst
        load(8'h81);
        cmd(1, 3'b111, 0, 5, 0, 0);
        tick();
        cmd(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("abort_pre_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_q", q, 0);
        chk("abort_busy", busy, 0);
        #1 rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            dones += int'(done);
        end
        chk("abort_no_done", dones, 0);

        // randomized run against the reference model (DUT state is zero after abort)
        mq = 0; rem = 0; mdone = 0;
        for (int i = 0; i < 400; i++) begin
            cmd($urandom_range(0, 3) != 0, 3'($urandom), 8'($urandom), 4'($urandom),
                1'($urandom), 1'($urandom));
            model_edge();
            tick();
            chk($sformatf("rnd%0d_q", i), q, mq);
            chk($sformatf("rnd%0d_busy", i), busy, rem > 0);
            chk($sformatf("rnd%0d_done", i), done, mdone);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/shift_register_universal.md
Name: shift_register_universal

Overview:
- Parametrised universal shift register; successor to the team's 8-bit right-shift/parallel-load register.
- Adds left shift, rotate, arithmetic shift, a clock enable, and an autonomous burst mode that shifts a programmed number of bits right and then signals completion.
- Used as a serializer/deserializer core and general data-path shifter in the memory and interface blocks.

Parameters:
- N, 8, register width in bits; N >= 2.
- LW, 4, width of the burst-length input; 2^LW - 1 >= N.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-low reset.
- en  input  1  command strobe; op is acted on only when en=1 and busy=0.
- op  input  3  operation select (encoding under Behaviour).
- d  input  N  parallel load data.
- len  input  LW  burst length in bits, for op=111 only.
- sin_l  input  1  serial input entering at MSB on right shifts.
- sin_r  input  1  serial input entering at LSB on left shifts.
- q  output  N  register contents.
- sout_r  output  1  q[0], the right-shift serial out.
- sout_l  output  1  q[N-1], the left-shift serial out.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (reset=0, asynchronous):
  - q=0, busy=0, done=0, internal count=0.
  - sout_r and sout_l follow q, so both are 0.
  - A reset during a burst aborts it; done is not pulsed.
- All updates occur on the clk rising edge. When en=0 and busy=0, q holds.
- op encoding (applies when en=1 and busy=0):
  - 000 hold.
  - 001 shift right: q <= {sin_l, q[N-1:1]}.
  - 010 shift left: q <= {q[N-2:0], sin_r}.
  - 011 rotate right: q <= {q[0], q[N-1:1]}.
  - 100 rotate left: q <= {q[N-2:0], q[N-1]}.
  - 101 arithmetic shift right: q <= {q[N-1], q[N-1:1]}; sin_l is ignored.
  - 110 parallel load: q <= d.
  - 111 burst start: count <= min(len, N), clamped; no shift on the start edge.
    - If the clamped length is nonzero, busy <= 1.
    - If len=0, busy stays 0 and done pulses on the next cycle.
- Burst state machine, states IDLE and SHIFT:
  - IDLE -> SHIFT on a burst start with nonzero length.
  - In SHIFT, each cycle: q <= {sin_l, q[N-1:1]}; count decrements.
  - en and op are ignored while busy=1, and no command is queued.
  - On the cycle the last shift occurs (count 1 -> 0): busy <= 0 and done <= 1 on that same edge, so done is high for exactly one cycle.
  - SHIFT -> IDLE on that edge. A new command may be accepted in the cycle where done=1.
- Latency:
  - Single-cycle ops: result visible on q one cycle after the accepting edge.
  - Burst of L bits: busy is high for L cycles; total duration from the start edge to the done edge is L+1 edges.
- done is 0 whenever not pulsing. busy and done are never both 1.
- Clamping: len > N is treated as N. After a burst of N bits, all of q came from sin_l.

Test Plan:
- Reset: drive reset=0 mid-operation with q=8'hA5 -> q=0, busy=0, done=0 immediately, without waiting for a clock edge.
- Basic ops: load 8'hB4, then apply each op for one cycle with sin_l=1, sin_r=0:
  - shr -> 8'hDA.
  - From 8'hB4: shl -> 8'h68; ror -> 8'h5A; rol -> 8'h69; asr -> 8'hDA.
  - With en=0, q holds.
- Burst: load 8'h81, op=111, len=3, sin_l=0:
  - busy is high for 3 cycles; sout_r sequence is 1, 0, 0 before each shift.
  - Final q=8'h10; done is a one-cycle pulse on the edge where busy falls.
- Lockout and clamping:
  - During a burst, pulse en with op=110, d=8'hFF -> ignored; q is unaffected by d.
  - len=15 with N=8 -> exactly 8 shifts.
  - len=0 -> no shift, busy=0, done pulses once on the next cycle.
- Back-to-back: issue op=110 with d=8'h3C in the done cycle -> accepted; next q=8'h3C.
- Abort: assert reset two cycles into a len=5 burst -> q=0, busy=0; done never pulses.
